// File: rtl/countdown_timer_ctrl_if.sv
// Control/status bundle between software-side control logic and the
// countdown timer controller.
interface countdown_timer_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             pause;
  logic             abort;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             busy;
  logic             paused;
  logic             done;

  // Control side: issues commands, observes counter status.
  modport master (
    output start, pause, abort, auto_reload, load_val,
    input  count, tick, busy, paused, done
  );

  // Timer side: accepts commands, reports counter status.
  modport slave (
    input  start, pause, abort, auto_reload, load_val,
    output count, tick, busy, paused, done
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: loads a start value, decrements once every
// PRESCALE running cycles, supports pause, abort and auto-reload, and
// strobes done for the single cycle spent at terminal count.
module countdown_timer_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input logic                  clk,
  input logic                  reset,
  countdown_timer_ctrl_if.slave bus
);

  // A single-cycle prescaler still needs one bit; it simply stays at zero.
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] count_q, count_nx;
  logic [PS_W-1:0]  psc_q, psc_nx;
  logic             busy_q, paused_q, done_q;
  logic             tick_w;
  logic             load_nz;

  assign load_nz = (bus.load_val != '0);

  // A step happens only while running undisturbed with the prescaler at its last phase.
  assign tick_w = (state_q == RUN) && !bus.abort && !bus.pause && (psc_q == PS_LAST);

  assign bus.count  = count_q;
  assign bus.tick   = tick_w;
  assign bus.busy   = busy_q;
  assign bus.paused = paused_q;
  assign bus.done   = done_q;

  // State, counter, prescaler and flag registers; flags decode the next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      psc_q    <= '0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_nx;
      count_q  <= count_nx;
      psc_q    <= psc_nx;
      busy_q   <= (state_nx == RUN) || (state_nx == HOLD);
      paused_q <= (state_nx == HOLD);
      done_q   <= (state_nx == DONE);
    end
  end

  // Next-state, counter and prescaler update; abort outranks pause, which
  // outranks stepping or starting.
  always_comb begin
    state_nx = state_q;
    count_nx = count_q;
    psc_nx   = psc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.abort) begin
          count_nx = '0;
        end else if (bus.start) begin
          if (load_nz) begin
            count_nx = bus.load_val;
            psc_nx   = '0;
            state_nx = RUN;
          end else begin
            state_nx = DONE;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          count_nx = '0;
          psc_nx   = '0;
          state_nx = IDLE;
        end else if (bus.pause) begin
          state_nx = HOLD;
        end else if (tick_w) begin
          psc_nx = '0;
          if (count_q == WIDTH'(1)) begin
            count_nx = '0;
            state_nx = DONE;
          end else if (count_q != '0) begin
            count_nx = count_q - WIDTH'(1);
          end
        end else begin
          psc_nx = psc_q + PS_W'(1);
        end
      end
      HOLD: begin
        if (bus.abort) begin
          count_nx = '0;
          psc_nx   = '0;
          state_nx = IDLE;
        end else if (!bus.pause) begin
          state_nx = RUN;
        end
      end
      DONE: begin
        if (!bus.abort && bus.auto_reload && load_nz) begin
          count_nx = bus.load_val;
          psc_nx   = '0;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
          if (bus.abort) count_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: a PRESCALE=4 instance for most scenarios
// and a PRESCALE=1 instance for the single-step run after reset.
module tb_countdown_timer_ctrl;

  typedef struct {
    string      name;
    logic [3:0] cnt;
    logic       tk;
    logic       bsy;
    logic       psd;
    logic       dn;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  countdown_timer_ctrl_if #(.WIDTH(4)) ctl ();
  countdown_timer_ctrl_if #(.WIDTH(4)) ctl1 ();

  countdown_timer_ctrl #(.WIDTH(4), .PRESCALE(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ctl.slave)
  );

  countdown_timer_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (ctl1.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    ctl.start = 0; ctl.pause = 0; ctl.abort = 0; ctl.auto_reload = 0; ctl.load_val = 0;
    ctl1.start = 0; ctl1.pause = 0; ctl1.abort = 0; ctl1.auto_reload = 0; ctl1.load_val = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    e.name = "reset"; e.cnt = 0; e.tk = 0; e.bsy = 0; e.psd = 0; e.dn = 0;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    n_cmp++;
    if ({ctl.tick, ctl.count, ctl.busy, ctl.paused, ctl.done} !== {e.tk, e.cnt, e.bsy, e.psd, e.dn}) begin
      n_bad++;
      $display("FAIL %s: got tick=%b count=%0d busy=%b paused=%b done=%b, expected tick=%b count=%0d busy=%b paused=%b done=%b",
               e.name, ctl.tick, ctl.count, ctl.busy, ctl.paused, ctl.done, e.tk, e.cnt, e.bsy, e.psd, e.dn);
    end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_basic();
    exp_t e;
    logic t;
    for (int k = 0; k <= 13; k++) begin
      ctl.start = (k == 0); ctl.load_val = 4'd3;
      e.name = "basic";
      e.tk  = (k >= 1) && (k <= 12) && (k % 4 == 0);
      e.cnt = (k == 0) ? 4'd3 : (k >= 12) ? 4'd0 : 4'(3 - k / 4);
      e.bsy = (k < 12); e.psd = 0; e.dn = (k == 12);
      sb.push_back(e);
      #1 t = ctl.tick;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({t, ctl.count, ctl.busy, ctl.paused, ctl.done} !== {e.tk, e.cnt, e.bsy, e.psd, e.dn}) begin
        n_bad++;
        $display("FAIL %s k=%0d: got tick=%b count=%0d busy=%b paused=%b done=%b, expected tick=%b count=%0d busy=%b paused=%b done=%b",
                 e.name, k, t, ctl.count, ctl.busy, ctl.paused, ctl.done, e.tk, e.cnt, e.bsy, e.psd, e.dn);
      end
    end
    drive_idle();
  endtask

  task automatic test_pause();
    exp_t e;
    logic t;
    for (int k = 0; k <= 12; k++) begin
      ctl.start = (k == 0); ctl.load_val = 4'd5;
      ctl.pause = (k >= 4) && (k <= 9);
      ctl.abort = (k == 12);
      e.name = "pause";
      e.tk  = (k == 11);
      e.cnt = (k == 12) ? 4'd0 : (k == 11) ? 4'd4 : 4'd5;
      e.bsy = (k != 12);
      e.psd = (k >= 4) && (k <= 9);
      e.dn  = 0;
      sb.push_back(e);
      #1 t = ctl.tick;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({t, ctl.count, ctl.busy, ctl.paused, ctl.done} !== {e.tk, e.cnt, e.bsy, e.psd, e.dn}) begin
        n_bad++;
        $display("FAIL %s k=%0d: got tick=%b count=%0d busy=%b paused=%b done=%b, expected tick=%b count=%0d busy=%b paused=%b done=%b",
                 e.name, k, t, ctl.count, ctl.busy, ctl.paused, ctl.done, e.tk, e.cnt, e.bsy, e.psd, e.dn);
      end
    end
    drive_idle();
  endtask

  task automatic test_abort();
    exp_t e;
    logic t;
    for (int k = 0; k <= 12; k++) begin
      ctl.start = (k == 0) || (k == 7); ctl.load_val = 4'd7;
      ctl.pause = (k >= 8) && (k <= 10);
      ctl.abort = (k == 3) || (k == 10);
      e.name = (k < 7) ? "abort_run" : "abort_hold";
      e.tk  = 0;
      e.cnt = ((k <= 2) || ((k >= 7) && (k <= 9))) ? 4'd7 : 4'd0;
      e.bsy = (k <= 2) || ((k >= 7) && (k <= 9));
      e.psd = (k == 8) || (k == 9);
      e.dn  = 0;
      sb.push_back(e);
      #1 t = ctl.tick;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({t, ctl.count, ctl.busy, ctl.paused, ctl.done} !== {e.tk, e.cnt, e.bsy, e.psd, e.dn}) begin
        n_bad++;
        $display("FAIL %s k=%0d: got tick=%b count=%0d busy=%b paused=%b done=%b, expected tick=%b count=%0d busy=%b paused=%b done=%b",
                 e.name, k, t, ctl.count, ctl.busy, ctl.paused, ctl.done, e.tk, e.cnt, e.bsy, e.psd, e.dn);
      end
    end
    drive_idle();
  endtask

  task automatic test_auto_reload();
    exp_t e;
    logic t;
    int   p;
    for (int k = 0; k <= 27; k++) begin
      ctl.start = (k == 0); ctl.load_val = 4'd2;
      ctl.auto_reload = (k <= 18);
      e.name = "auto_reload";
      if (k == 0) begin
        e.tk = 0; e.cnt = 4'd2; e.bsy = 1; e.dn = 0;
      end else begin
        p = (k - 1) % 9;
        e.tk  = (p < 8) && ((p + 1) % 4 == 0);
        e.cnt = (p < 8) ? 4'(2 - (p + 1) / 4) : ((k == 27) ? 4'd0 : 4'd2);
        e.bsy = ((p < 7) || (p == 8)) && (k != 27);
        e.dn  = (p == 7);
      end
      e.psd = 0;
      sb.push_back(e);
      #1 t = ctl.tick;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({t, ctl.count, ctl.busy, ctl.paused, ctl.done} !== {e.tk, e.cnt, e.bsy, e.psd, e.dn}) begin
        n_bad++;
        $display("FAIL %s k=%0d: got tick=%b count=%0d busy=%b paused=%b done=%b, expected tick=%b count=%0d busy=%b paused=%b done=%b",
                 e.name, k, t, ctl.count, ctl.busy, ctl.paused, ctl.done, e.tk, e.cnt, e.bsy, e.psd, e.dn);
      end
    end
    drive_idle();
  endtask

  task automatic test_zero_load();
    exp_t       e;
    logic       t;
    logic [3:0] lv [4];
    lv[0] = 4'd0; lv[1] = 4'd5; lv[2] = 4'd3; lv[3] = 4'd9;
    for (int k = 0; k <= 5; k++) begin
      ctl.start = (k <= 3);
      ctl.load_val = (k <= 3) ? lv[k] : 4'd0;
      ctl.abort = (k == 5);
      e.name = (k <= 1) ? "zero_load" : "start_ignored";
      e.tk  = 0;
      e.cnt = ((k >= 2) && (k <= 4)) ? 4'd3 : 4'd0;
      e.bsy = (k >= 2) && (k <= 4);
      e.psd = 0;
      e.dn  = (k == 0);
      sb.push_back(e);
      #1 t = ctl.tick;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({t, ctl.count, ctl.busy, ctl.paused, ctl.done} !== {e.tk, e.cnt, e.bsy, e.psd, e.dn}) begin
        n_bad++;
        $display("FAIL %s k=%0d: got tick=%b count=%0d busy=%b paused=%b done=%b, expected tick=%b count=%0d busy=%b paused=%b done=%b",
                 e.name, k, t, ctl.count, ctl.busy, ctl.paused, ctl.done, e.tk, e.cnt, e.bsy, e.psd, e.dn);
      end
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic t;
    for (int k = 0; k <= 3; k++) begin
      ctl.start = (k == 0); ctl.load_val = 4'd9;
      e.name = "pre_reset"; e.tk = 0; e.cnt = 4'd9; e.bsy = 1; e.psd = 0; e.dn = 0;
      sb.push_back(e);
      #1 t = ctl.tick;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({t, ctl.count, ctl.busy, ctl.paused, ctl.done} !== {e.tk, e.cnt, e.bsy, e.psd, e.dn}) begin
        n_bad++;
        $display("FAIL %s k=%0d: got tick=%b count=%0d busy=%b paused=%b done=%b, expected tick=%b count=%0d busy=%b paused=%b done=%b",
                 e.name, k, t, ctl.count, ctl.busy, ctl.paused, ctl.done, e.tk, e.cnt, e.bsy, e.psd, e.dn);
      end
    end
    ctl.start = 0;
    #2 reset = 1;
    e.name = "async_reset"; e.tk = 0; e.cnt = 4'd0; e.bsy = 0; e.psd = 0; e.dn = 0;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({ctl.tick, ctl.count, ctl.busy, ctl.paused, ctl.done} !== {e.tk, e.cnt, e.bsy, e.psd, e.dn}) begin
      n_bad++;
      $display("FAIL %s: got tick=%b count=%0d busy=%b paused=%b done=%b, expected tick=%b count=%0d busy=%b paused=%b done=%b",
               e.name, ctl.tick, ctl.count, ctl.busy, ctl.paused, ctl.done, e.tk, e.cnt, e.bsy, e.psd, e.dn);
    end
    @(posedge clk); #1;
    reset = 0;
    // Single-step run on the PRESCALE=1 instance.
    for (int k = 0; k <= 2; k++) begin
      ctl1.start = (k == 0); ctl1.load_val = 4'd1;
      e.name = "prescale1";
      e.tk  = (k == 1);
      e.cnt = (k == 0) ? 4'd1 : 4'd0;
      e.bsy = (k == 0);
      e.psd = 0;
      e.dn  = (k == 1);
      sb.push_back(e);
      #1 t = ctl1.tick;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({t, ctl1.count, ctl1.busy, ctl1.paused, ctl1.done} !== {e.tk, e.cnt, e.bsy, e.psd, e.dn}) begin
        n_bad++;
        $display("FAIL %s k=%0d: got tick=%b count=%0d busy=%b paused=%b done=%b, expected tick=%b count=%0d busy=%b paused=%b done=%b",
                 e.name, k, t, ctl1.count, ctl1.busy, ctl1.paused, ctl1.done, e.tk, e.cnt, e.bsy, e.psd, e.dn);
      end
    end
    drive_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk   = 0;
    reset = 1;
    drive_idle();
    test_reset();
    test_basic();
    test_pause();
    test_abort();
    test_auto_reload();
    test_zero_load();
    test_async_reset();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
Controller for a WIDTH-bit synchronous down counter. It loads a start value, gates count-down steps through a programmable prescaler, and supports pause, abort and auto-reload. It raises a one-cycle done strobe at terminal count. It sits between software/control logic and the counter datapath.

Parameters:
WIDTH, 4, counter width in bits
PRESCALE, 4, clk cycles per decrement step (>=1; 1 = decrement every RUN cycle)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  load load_val and begin counting; sampled only in IDLE
pause  input  1  level; freezes counter and prescaler while high
abort  input  1  level/pulse; returns to IDLE and clears count
auto_reload  input  1  on terminal count, reload load_val and continue
load_val  input  WIDTH  start value, sampled at start and at reload
count  output  WIDTH  current counter value (registered)
tick  output  1  combinational; high in the cycle a decrement occurs
busy  output  1  registered; high in RUN or HOLD
paused  output  1  registered; high in HOLD
done  output  1  registered; high for exactly the one cycle spent in DONE

Behaviour:
- Reset (async, any time, including mid-count):
  - state=IDLE, count=0, prescaler=0.
  - busy=paused=done=0; tick=0.
- States: IDLE, RUN, HOLD, DONE.
- Priority in every state: abort > pause > tick/start.
- IDLE:
  - count held.
  - start=1 and load_val!=0: count<=load_val, prescaler<=0, go RUN.
  - start=1 and load_val==0: go DONE; count stays 0.
  - pause is ignored in IDLE.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - tick = (state==RUN) & !abort & !pause & (prescaler==PRESCALE-1).
  - On tick, count<=count-1.
  - On tick with count==1: count<=0, go DONE.
  - pause=1 (and no abort): go HOLD. No decrement that cycle, even if the prescaler is at PRESCALE-1. The prescaler value is kept.
  - abort=1: count<=0, prescaler<=0, go IDLE.
  - start is ignored.
- HOLD:
  - count and prescaler frozen.
  - pause=0: go RUN. Resumes from the saved prescaler value, so a pause taken at PRESCALE-1 ticks on the first RUN cycle.
  - abort=1: go IDLE, count<=0.
- DONE (exactly one cycle; done=1):
  - auto_reload=1 and load_val!=0 and abort=0: count<=load_val, prescaler<=0, go RUN.
  - Otherwise go IDLE. If abort=1, also count<=0.
  - start is ignored in DONE.
- Counter never underflows: count decrements only while nonzero, and the terminal decrement is 1->0.
- Steps per run: a run started from value V takes V*PRESCALE RUN cycles to reach DONE, excluding HOLD cycles.
- Flag encoding: busy, paused and done are registered state decodes. They change on the same edge as the state.

Test Plan:
All scenarios use WIDTH=4, PRESCALE=4 unless noted.
1. Basic count: start=1, load_val=3 sampled at edge 0.
   -> count=3 after e0; tick high in the cycles before e4/e8/e12.
   -> count=2,1,0 after e4/e8/e12; done=1 between e12 and e13.
   -> IDLE and busy=0 after e13.
2. Pause: count=5, assert pause in the cycle the prescaler is 3, hold for 6 cycles, then release.
   -> tick=0 and count=5 throughout, paused=1.
   -> after release, the first RUN cycle ticks and count becomes 4.
3. Abort: abort=1 for one cycle in RUN with count=7, and separately in HOLD.
   -> next edge: count=0, busy=0, done never asserts.
4. Auto-reload: auto_reload=1, load_val=2.
   -> done pulses every 9 cycles (8 RUN + 1 DONE); count sequence 2,1,0,2,1,0...
   -> deassert auto_reload: next DONE leads to IDLE.
5. Zero load: start with load_val=0.
   -> done=1 the next cycle, count stays 0, busy stays 0.
   -> start asserted during RUN or DONE has no effect.
6. Async reset: assert reset mid-RUN between clock edges (count=9).
   -> count=0, busy=0 immediately, without waiting for a clock edge.
   -> after release, start with load_val=1, PRESCALE=1: done follows after 1 RUN cycle.
